// File: rtl/acc_dispatch_unit.sv
// Stamp-arbitrated dispatch of core requests onto N_ACC accumulators, each
// driving an external pipelined adder with result bypass on the return cycle.
module acc_dispatch_unit #(
    parameter int N_CORE   = 6,
    parameter int N_ACC    = 3,
    parameter int LATENCY  = 6,
    parameter int GC_WIDTH = 8,
    parameter int DW       = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [N_CORE*N_ACC-1:0]         req_valid,
    output logic [N_CORE*N_ACC-1:0]         req_ready,
    input  logic [N_CORE*N_ACC*DW-1:0]      req_data,
    input  logic [N_CORE*N_ACC*GC_WIDTH-1:0] req_stamp,
    input  logic                            order_max,
    input  logic [N_ACC-1:0]                acc_load,
    input  logic [N_ACC*DW-1:0]             acc_load_data,
    output logic [N_ACC-1:0]                add_valid,
    output logic [N_ACC*DW-1:0]             add_a,
    output logic [N_ACC*DW-1:0]             add_b,
    input  logic [N_ACC*DW-1:0]             add_result,
    output logic [N_ACC*DW-1:0]             acc_value,
    output logic [N_ACC-1:0]                acc_busy,
    output logic                            all_ready,
    output logic                            no_req
);

    localparam int CNTW = $clog2(LATENCY) + 1;
    localparam int CW   = (N_CORE > 1) ? $clog2(N_CORE) : 1;
    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(LATENCY);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    // count[a] == 1 marks the cycle whose add_result belongs to accumulator a.
    logic [CNTW-1:0]              count      [N_ACC];
    logic [DW-1:0]                acc_q      [N_ACC];
    logic signed [GC_WIDTH-1:0]   best_stamp [N_ACC];
    logic [CW-1:0]                win_core   [N_ACC];
    logic [N_ACC-1:0]             win_found;
    logic [N_ACC-1:0]             slot_open;
    logic [N_ACC-1:0]             dispatch;

    // Winner search: strict comparison keeps the lowest core index on ties.
    always_comb begin
        logic signed [GC_WIDTH-1:0] cand;
        logic                       better;
        cand   = '0;
        better = 1'b0;
        for (int a = 0; a < N_ACC; a++) begin
            win_found[a]  = 1'b0;
            win_core[a]   = '0;
            best_stamp[a] = '0;
            for (int c = 0; c < N_CORE; c++) begin
                if (req_valid[c*N_ACC+a]) begin
                    cand   = $signed(req_stamp[(c*N_ACC+a)*GC_WIDTH +: GC_WIDTH]);
                    better = order_max ? (cand > best_stamp[a]) : (cand < best_stamp[a]);
                    if (!win_found[a] || better) begin
                        win_found[a]  = 1'b1;
                        win_core[a]   = CW'(c);
                        best_stamp[a] = cand;
                    end
                end
            end
        end
    end

    // Handshake: a transfer to accumulator a happens in any cycle where
    // req_valid and req_ready are both high on the same bit; ready is offered
    // only to the current winner, never depends on its own ready, and is
    // withheld during reset, a load request, or while an older add is more
    // than one cycle from returning.
    always_comb begin
        req_ready = '0;
        for (int a = 0; a < N_ACC; a++) begin
            slot_open[a] = !reset && !acc_load[a] && (count[a] <= CNT_ONE);
            for (int c = 0; c < N_CORE; c++) begin
                if (slot_open[a] && win_found[a] && (win_core[a] == CW'(c)))
                    req_ready[c*N_ACC+a] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int a = 0; a < N_ACC; a++) begin
            dispatch[a] = 1'b0;
            for (int c = 0; c < N_CORE; c++)
                dispatch[a] = dispatch[a] | (req_valid[c*N_ACC+a] & req_ready[c*N_ACC+a]);
        end
    end

    // Operand mux; a dispatch on the return cycle takes the fresh result.
    always_comb begin
        add_a = '0;
        add_b = '0;
        for (int a = 0; a < N_ACC; a++) begin
            add_a[a*DW +: DW] = (count[a] == CNT_ONE) ? add_result[a*DW +: DW] : acc_q[a];
            for (int c = 0; c < N_CORE; c++) begin
                if (win_core[a] == CW'(c))
                    add_b[a*DW +: DW] = req_data[(c*N_ACC+a)*DW +: DW];
            end
        end
    end

    assign add_valid = dispatch;

    always_ff @(posedge clk) begin
        for (int a = 0; a < N_ACC; a++) begin
            if (reset) begin
                count[a] <= '0;
                acc_q[a] <= '0;
            end else begin
                if (dispatch[a])
                    count[a] <= CNT_LOAD;
                else if (count[a] != '0)
                    count[a] <= count[a] - CNT_ONE;

                if (count[a] == CNT_ONE)
                    acc_q[a] <= add_result[a*DW +: DW];
                else if (acc_load[a] && (count[a] == '0))
                    acc_q[a] <= acc_load_data[a*DW +: DW];
            end
        end
    end

    always_comb begin
        all_ready = 1'b1;
        for (int a = 0; a < N_ACC; a++) begin
            acc_value[a*DW +: DW] = acc_q[a];
            acc_busy[a]           = (count[a] != '0);
            all_ready             = all_ready & (count[a] <= CNT_ONE);
        end
    end

    assign no_req = ~|req_valid;

endmodule

// File: tb/tb_acc_dispatch_unit.sv
// Bench for acc_dispatch_unit: float-adder pipeline model, cycle-level
// reference model with per-cycle compare, and directed scenarios.
module tb_acc_dispatch_unit;

    localparam int N_CORE   = 6;
    localparam int N_ACC    = 3;
    localparam int LATENCY  = 6;
    localparam int GC_WIDTH = 8;
    localparam int DW       = 32;
    localparam int NR       = N_CORE * N_ACC;

    localparam logic [31:0] F_0P5 = 32'h3F000000;
    localparam logic [31:0] F_1P0 = 32'h3F800000;
    localparam logic [31:0] F_1P5 = 32'h3FC00000;
    localparam logic [31:0] F_2P0 = 32'h40000000;
    localparam logic [31:0] F_3P0 = 32'h40400000;
    localparam logic [31:0] F_7P0 = 32'h40E00000;
    localparam logic [31:0] F_8P0 = 32'h41000000;

    logic                        clk;
    logic                        reset;
    logic [NR-1:0]               req_valid;
    logic [NR-1:0]               req_ready;
    logic [NR*DW-1:0]            req_data;
    logic [NR*GC_WIDTH-1:0]      req_stamp;
    logic                        order_max;
    logic [N_ACC-1:0]            acc_load;
    logic [N_ACC*DW-1:0]         acc_load_data;
    logic [N_ACC-1:0]            add_valid;
    logic [N_ACC*DW-1:0]         add_a;
    logic [N_ACC*DW-1:0]         add_b;
    logic [N_ACC*DW-1:0]         add_result;
    logic [N_ACC*DW-1:0]         acc_value;
    logic [N_ACC-1:0]            acc_busy;
    logic                        all_ready;
    logic                        no_req;

    int chk_cnt = 0;
    int err_cnt = 0;

    acc_dispatch_unit #(
        .N_CORE(N_CORE), .N_ACC(N_ACC), .LATENCY(LATENCY),
        .GC_WIDTH(GC_WIDTH), .DW(DW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_stamp(req_stamp),
        .order_max(order_max),
        .acc_load(acc_load), .acc_load_data(acc_load_data),
        .add_valid(add_valid), .add_a(add_a), .add_b(add_b),
        .add_result(add_result),
        .acc_value(acc_value), .acc_busy(acc_busy),
        .all_ready(all_ready), .no_req(no_req)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- float helpers (normal numbers and zero) ----------------
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        logic [10:0] e;
        if (f[30:0] == 31'd0) return 0.0;
        e = 11'(f[30:23]) + 11'd896;
        d = {f[31], e, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- external adder: fixed LATENCY pipeline ----------------
    logic [DW-1:0] pipe [N_ACC][LATENCY];

    always @(posedge clk) begin
        for (int a = 0; a < N_ACC; a++) begin
            pipe[a][0] <= add_valid[a] ?
                r2f(f2r(add_a[a*DW +: DW]) + f2r(add_b[a*DW +: DW])) : 32'hDEADBEEF;
            for (int s = 1; s < LATENCY; s++) pipe[a][s] <= pipe[a][s-1];
        end
    end

    always_comb begin
        for (int a = 0; a < N_ACC; a++) add_result[a*DW +: DW] = pipe[a][LATENCY-1];
    end

    // ---------------- reference model ----------------
    // Each accumulator remembers the absolute cycle its pending sum returns.
    logic [31:0] m_val [N_ACC];
    logic [31:0] m_sum [N_ACC];
    int          m_ret [N_ACC];
    int          cyc = 0;
    logic [31:0] ea [N_ACC];
    logic [31:0] eb [N_ACC];
    logic [NR-1:0]    exp_ready;
    logic [N_ACC-1:0] exp_valid;
    logic [N_ACC-1:0] exp_busy;
    logic             exp_all;

    initial begin
        for (int a = 0; a < N_ACC; a++) begin
            m_val[a] = '0;
            m_sum[a] = '0;
            m_ret[a] = -1;
        end
    end

    function automatic int stamp_of(input int c, input int a);
        logic signed [GC_WIDTH-1:0] s;
        s = req_stamp[(c*N_ACC+a)*GC_WIDTH +: GC_WIDTH];
        return int'(s);
    endfunction

    // Extreme stamp first, then the first core holding it.
    function automatic int pick(input int a);
        int best;
        best = order_max ? -1000000 : 1000000;
        for (int c = 0; c < N_CORE; c++) begin
            if (req_valid[c*N_ACC+a]) begin
                if (order_max && stamp_of(c, a) > best) best = stamp_of(c, a);
                if (!order_max && stamp_of(c, a) < best) best = stamp_of(c, a);
            end
        end
        for (int c = 0; c < N_CORE; c++)
            if (req_valid[c*N_ACC+a] && stamp_of(c, a) == best) return c;
        return -1;
    endfunction

    always @(negedge clk) begin
        int w;
        exp_ready = '0;
        exp_valid = '0;
        exp_busy  = '0;
        exp_all   = 1'b1;
        for (int a = 0; a < N_ACC; a++) begin
            w = pick(a);
            exp_busy[a] = (m_ret[a] >= 0) && (cyc <= m_ret[a]);
            exp_all = exp_all && ((m_ret[a] < 0) || (cyc == m_ret[a]));
            ea[a] = (m_ret[a] == cyc) ? m_sum[a] : m_val[a];
            eb[a] = (w >= 0) ? req_data[(w*N_ACC+a)*DW +: DW] : '0;
            if (!reset && !acc_load[a] && ((m_ret[a] < 0) || (cyc == m_ret[a])) && w >= 0) begin
                exp_ready[w*N_ACC+a] = 1'b1;
                exp_valid[a] = 1'b1;
            end
        end

        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        chk("add_valid", 64'(add_valid), 64'(exp_valid));
        chk("acc_busy", 64'(acc_busy), 64'(exp_busy));
        chk("all_ready", 64'(all_ready), 64'(exp_all));
        chk("no_req", 64'(no_req), 64'(req_valid == '0));
        for (int a = 0; a < N_ACC; a++) begin
            chk("acc_value", 64'(acc_value[a*DW +: DW]), 64'(m_val[a]));
            if (exp_valid[a]) begin
                chk("add_a", 64'(add_a[a*DW +: DW]), 64'(ea[a]));
                chk("add_b", 64'(add_b[a*DW +: DW]), 64'(eb[a]));
            end
        end

        for (int a = 0; a < N_ACC; a++) begin
            if (reset) begin
                m_val[a] = '0;
                m_ret[a] = -1;
            end else begin
                if (m_ret[a] == cyc) begin
                    m_val[a] = m_sum[a];
                    m_ret[a] = -1;
                end else if (acc_load[a] && m_ret[a] < 0) begin
                    m_val[a] = acc_load_data[a*DW +: DW];
                end
                if (exp_valid[a]) begin
                    m_sum[a] = r2f(f2r(ea[a]) + f2r(eb[a]));
                    m_ret[a] = cyc + LATENCY;
                end
            end
        end
        cyc++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int c, input int a, input logic [31:0] d,
                           input logic [GC_WIDTH-1:0] s);
        req_valid[c*N_ACC+a] = 1'b1;
        req_data[(c*N_ACC+a)*DW +: DW] = d;
        req_stamp[(c*N_ACC+a)*GC_WIDTH +: GC_WIDTH] = s;
    endtask

    task automatic clr_req();
        req_valid = '0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int k;
        int busy_n;
        reset = 1'b1;
        req_valid = '0;
        req_data = '0;
        req_stamp = '0;
        order_max = 1'b1;
        acc_load = '0;
        acc_load_data = '0;
        repeat (2) tick();
        reset = 1'b0;
        #1;
        chk("rst_busy", 64'(acc_busy), 64'd0);
        chk("rst_all_ready", 64'(all_ready), 64'd1);
        chk("rst_add_valid", 64'(add_valid), 64'd0);
        chk("rst_no_req", 64'(no_req), 64'd1);

        // single add: core2 -> acc0, 1.5
        set_req(2, 0, F_1P5, 8'sd3);
        #1;
        chk("single_valid", 64'(add_valid), 64'b001);
        chk("single_a", 64'(add_a[31:0]), 64'd0);
        chk("single_b", 64'(add_b[31:0]), 64'(F_1P5));
        chk("single_no_req", 64'(no_req), 64'd0);
        tick();
        clr_req();
        busy_n = 0;
        for (int i = 0; i < 8; i++) begin
            if (acc_busy[0]) busy_n++;
            tick();
        end
        chk("single_busy_cycles", 64'(busy_n), 64'd6);
        chk("single_result", 64'(acc_value[31:0]), 64'(F_1P5));

        // arbitration on acc1: stamps 5 / -2 / 5 from cores 0 / 1 / 4
        order_max = 1'b1;
        set_req(0, 1, F_1P0, 8'sd5);
        set_req(1, 1, F_2P0, -8'sd2);
        set_req(4, 1, F_0P5, 8'sd5);
        #1;
        chk("arb_max", 64'(req_ready), 64'h00002);
        order_max = 1'b0;
        #1;
        chk("arb_min", 64'(req_ready), 64'h00010);
        tick();
        clr_req();
        repeat (8) tick();
        chk("arb_result", 64'(acc_value[63:32]), 64'(F_2P0));

        // bypass on acc2: 2.0 then a held 1.0 request
        set_req(3, 2, F_2P0, 8'sd0);
        tick();
        req_data[(3*N_ACC+2)*DW +: DW] = F_1P0;
        k = 0;
        while (!req_ready[3*N_ACC+2] && k < 10) begin
            tick();
            k++;
        end
        chk("bypass_wait", 64'(k), 64'd5);
        chk("bypass_add_a", 64'(add_a[95:64]), 64'(F_2P0));
        chk("bypass_result_in", 64'(add_result[95:64]), 64'(F_2P0));
        tick();
        clr_req();
        repeat (8) tick();
        chk("bypass_final", 64'(acc_value[95:64]), 64'(F_3P0));

        // load on idle acc0 blocks the competing request
        set_req(1, 0, F_1P0, 8'sd0);
        acc_load[0] = 1'b1;
        acc_load_data[31:0] = F_7P0;
        #1;
        chk("load_blocks_ready", 64'(req_ready[1*N_ACC+0]), 64'd0);
        tick();
        acc_load = '0;
        clr_req();
        chk("load_idle", 64'(acc_value[31:0]), 64'(F_7P0));
        // load while busy is ignored
        set_req(1, 0, F_1P0, 8'sd0);
        tick();
        clr_req();
        acc_load[0] = 1'b1;
        acc_load_data[31:0] = F_0P5;
        repeat (2) tick();
        acc_load = '0;
        repeat (7) tick();
        chk("load_busy_ignored", 64'(acc_value[31:0]), 64'(F_8P0));

        // reset three cycles after a dispatch
        set_req(0, 1, F_2P0, 8'sd0);
        tick();
        clr_req();
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("reset_no_writeback", 64'(acc_value[63:32]), 64'd0);
            tick();
        end

        // parallel dispatch to all three accumulators
        set_req(0, 0, F_1P0, 8'sd0);
        set_req(1, 1, F_1P0, 8'sd0);
        set_req(2, 2, F_1P0, 8'sd0);
        #1;
        chk("par_valid", 64'(add_valid), 64'b111);
        tick();
        clr_req();
        k = 0;
        while (!all_ready && k < 10) begin
            k++;
            tick();
        end
        chk("par_all_ready_wait", 64'(k), 64'd5);
        repeat (4) tick();
        chk("par_acc0", 64'(acc_value[31:0]), 64'(F_1P0));
        chk("par_acc1", 64'(acc_value[63:32]), 64'(F_1P0));
        chk("par_acc2", 64'(acc_value[95:64]), 64'(F_1P0));

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
